seq_serializer: RTL and testbench
=================================

// Module: seq_serializer
// PURPOSE
//   Upstream feeder for the 11011 sequence detector. Accepts parallel words on a valid/ready handshake
//   and drives them onto the 1-bit 'seq' line, one bit per clk cycle.
//   A one-word holding buffer behind the shift register gives gap-free back-to-back streaming.
//   Drives a fixed idle level between words.
// PARAMETERS
//   WIDTH     8     bits per input word; legal range 2..32
//   IDLE_BIT  1'b0  level on seq while no word is shifting (0 returns the detector toward its start state)
// PORTS
//   clk        input   1      system clock, 100 MHz
//   rstn       input   1      asynchronous, active-low reset
//   s_data     input   WIDTH  parallel word to serialize
//   s_valid    input   1      s_data valid
//   s_ready    output  1      block can take a word; transfer on s_valid && s_ready at posedge clk
//   seq        output  1      serial bit to the detector (register bit, glitch-free)
//   seq_valid  output  1      high while seq carries a data bit (state SHIFT)
//   busy       output  1      seq_valid || hold_full
// BEHAVIOUR
//   Reset (rstn=0, async): state=IDLE, sh=0, cnt=0, hold_full=0, hold=0.
//     Outputs: seq=IDLE_BIT, seq_valid=0, s_ready=1, busy=0. Reset mid-word drops all data, no partial flush.
//   s_ready = !hold_full (registered state only, no combinational path from s_valid).
//   States: IDLE, SHIFT. cnt is $clog2(WIDTH) bits and counts bits already emitted from sh.
//   IDLE: transfer at edge N -> sh=s_data, cnt=0, state=SHIFT.
//     First bit appears on seq in the cycle after edge N (latency 1).
//   SHIFT: seq=sh[WIDTH-1], seq_valid=1. At each edge, shift sh left by 1 and increment cnt.
//     A transfer while hold is empty writes hold and sets hold_full.
//   SHIFT, cnt==WIDTH-1 (last bit on seq) at edge, in priority order:
//     1) hold_full: sh=hold, hold_full=0, cnt=0, stay SHIFT
//     2) transfer this cycle: sh=s_data, cnt=0, stay SHIFT
//     3) otherwise: state=IDLE, seq returns to IDLE_BIT next cycle
//   Last bit with hold_full: s_ready=0, so no transfer can occur. The freed slot is offered the following cycle.
//   Throughput: with s_valid held high, words stream with zero idle bits between them.
//   s_data is sampled only on a transfer; later changes to s_data have no effect.
// CONFIGURATION
//   SER_LSB_FIRST_EN defined:
//     seq=sh[0], shift right, LSB emitted first.
//   SER_LSB_FIRST_EN undefined (default):
//     seq=sh[WIDTH-1], MSB emitted first.
//   Handshake, latency and idle behaviour are identical in both builds.
// STRUCTURE
//   Package seq_ser_pkg: state typedef (IDLE=1'b0, SHIFT=1'b1), localparam CNT_W=$clog2(WIDTH).
//   Sub-module ser_hold_buf: 1-entry buffer with hold and hold_full.
//     Interface: write on transfer while SHIFT, read on word boundary.
//   The FSM, counter and shift register stay in the top module.
// TESTING
//   1. Reset, no stimulus -> seq=0, seq_valid=0, s_ready=1, busy=0.
//      Assert rstn=0 asynchronously mid-cycle -> outputs return to reset values immediately.
//   2. Single word 8'hDB, MSB-first -> seq = 1,1,0,1,1,0,1,1 on the 8 cycles after the transfer, seq_valid=1 for those 8 cycles.
//      Cycle 9: seq=0, seq_valid=0.
//      Downstream detector flags 11011 (and the overlap).
//   3. Back-to-back 8'hDB, 8'h1B with s_valid held -> 16 contiguous valid bits.
//      s_ready=0 from the edge after the second transfer until the boundary when hold drains.
//   4. s_valid withheld after one word -> IDLE after the 8th bit.
//      New word 3 cycles later -> exactly 3 IDLE_BIT cycles between the words.
//   5. Reset asserted after 4 bits of 8'hFF -> seq=0 at once, hold cleared.
//      Next word after reset is serialized in full from bit 7.
//   6. Build with SER_LSB_FIRST_EN, word 8'h1B -> seq = 1,1,0,1,1,0,0,0.
//   Also sweep WIDTH=2 and WIDTH=32 for counter wrap at the word boundary.

Source files
------------

// File: rtl/seq_ser_pkg.sv
// ---------------------------------------------------------------------------
// seq_ser_pkg
//   Shared types and sizing helpers for the seq_serializer block.
//   - ser_state_e : serializer FSM state (IDLE=0, SHIFT=1)
//   - CNT_W       : bit-counter width for the default 8-bit word
//   - cnt_width() : bit-counter width for any legal WIDTH (2..32)
// ---------------------------------------------------------------------------
package seq_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Counter width for a given word width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage : seq_ser_pkg

// File: rtl/ser_hold_buf.sv
// ---------------------------------------------------------------------------
// ser_hold_buf
//   One-entry holding buffer that sits behind the serializer's shift
//   register, so a second word can be accepted while the first is shifting.
//   Ports:
//     clk, rstn      clock, asynchronous active-low reset
//     i_wr, i_wdata  write strobe and word (only issued while the slot is empty)
//     i_rd           read strobe at a word boundary (frees the slot)
//     o_data         buffered word
//     o_full         slot occupied
// ---------------------------------------------------------------------------
module ser_hold_buf
    import seq_ser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full
);

    logic [WIDTH-1:0] r_hold;
    logic             r_full;

    // NOTE: the data register is reset along with the flag; it is a single
    // word, so clearing it is cheap and keeps o_data deterministic.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hold <= '0;
            r_full <= 1'b0;
        end else if (i_wr) begin
            r_hold <= i_wdata;
            r_full <= 1'b1;
        end else if (i_rd) begin
            r_full <= 1'b0;
        end
    end

    assign o_data = r_hold;
    assign o_full = r_full;

endmodule : ser_hold_buf

// File: rtl/seq_serializer.sv
// ---------------------------------------------------------------------------
// seq_serializer
//   Accepts parallel words on a valid/ready handshake and drives them onto a
//   1-bit serial line, one bit per clock, with a one-word holding buffer so
//   back-to-back words stream with no gap. Drives IDLE_BIT between words.
//   Parameters:
//     WIDTH     bits per word (2..32)
//     IDLE_BIT  level on seq while no word is shifting
//   Ports:
//     clk, rstn          clock, asynchronous active-low reset
//     s_data, s_valid    input word and its valid
//     s_ready            slot available (= !hold_full, registered)
//     seq                serial bit (registered)
//     seq_valid          seq carries a data bit
//     busy               seq_valid || hold_full
//   Build option:
//     SER_LSB_FIRST_EN   defined: LSB emitted first; undefined: MSB first.
// ---------------------------------------------------------------------------
module seq_serializer
    import seq_ser_pkg::*;
#(
    parameter int   WIDTH    = DEFAULT_WIDTH,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             seq,
    output logic             seq_valid,
    output logic             busy
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    ser_state_e       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sh, w_sh_nxt, w_sh_shifted;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic             r_seq, w_seq_nxt, w_out_nxt;
    logic             w_xfer, w_last;
    logic             w_hold_wr, w_hold_rd, w_hold_full;
    logic [WIDTH-1:0] w_hold_data;

    assign s_ready = !w_hold_full;
    assign w_xfer  = s_valid && s_ready;
    assign w_last  = (r_state == SHIFT) && (r_cnt == LAST_CNT);

`ifdef SER_LSB_FIRST_EN
    assign w_sh_shifted = r_sh >> 1;
    assign w_out_nxt    = w_sh_nxt[0];
`else
    assign w_sh_shifted = r_sh << 1;
    assign w_out_nxt    = w_sh_nxt[WIDTH-1];
`endif

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_sh_nxt    = r_sh;
        w_cnt_nxt   = r_cnt;
        w_hold_wr   = 1'b0;
        w_hold_rd   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_sh_nxt    = s_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_last) begin
                    // Word boundary: the buffered word wins over a new
                    // transfer (none can occur while the slot is full).
                    if (w_hold_full) begin
                        w_sh_nxt  = w_hold_data;
                        w_cnt_nxt = '0;
                        w_hold_rd = 1'b1;
                    end else if (w_xfer) begin
                        w_sh_nxt  = s_data;
                        w_cnt_nxt = '0;
                    end else begin
                        w_sh_nxt    = w_sh_shifted;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_sh_nxt  = w_sh_shifted;
                    w_cnt_nxt = r_cnt + 1'b1;
                    // Mid-word transfer can only happen with the slot empty.
                    w_hold_wr = w_xfer;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // seq is registered from the next-state view so it changes only on
        // the clock edge and never glitches.
        w_seq_nxt = (w_state_nxt == SHIFT) ? w_out_nxt : IDLE_BIT;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sh  <= '0;
            r_cnt <= '0;
            r_seq <= IDLE_BIT;
        end else begin
            r_sh  <= w_sh_nxt;
            r_cnt <= w_cnt_nxt;
            r_seq <= w_seq_nxt;
        end
    end

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .rstn    (rstn),
        .i_wr    (w_hold_wr),
        .i_wdata (s_data),
        .i_rd    (w_hold_rd),
        .o_data  (w_hold_data),
        .o_full  (w_hold_full)
    );

    assign seq       = r_seq;
    assign seq_valid = (r_state == SHIFT);
    assign busy      = seq_valid || w_hold_full;

endmodule : seq_serializer

// File: tb/tb_seq_serializer.sv
// ---------------------------------------------------------------------------
// tb_seq_serializer
//   Scoreboard bench. Each accepted word is expanded into its serial bits
//   in emission order and queued; a monitor on the falling edge pops one bit
//   per valid cycle. With Q = queued bits (including the one on seq now):
//   seq_valid = busy = (Q > 0), s_ready = (Q <= WIDTH), seq = IDLE_BIT when
//   Q == 0. Main instance WIDTH=8; two sweep instances at WIDTH=2 and 32.
// ---------------------------------------------------------------------------
module tb_seq_serializer;

    localparam int   W        = 8;
    localparam logic IDLE_BIT = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rstn    = 1'b0;
    logic [W-1:0] s_data  = '0;
    logic         s_valid = 1'b0;
    logic         s_ready, seq, seq_valid, busy;

    seq_serializer #(
        .WIDTH    (W),
        .IDLE_BIT (IDLE_BIT)
    ) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .seq       (seq),
        .seq_valid (seq_valid),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- main instance scoreboard ----------------
    bit       exp_q[$];
    int       det_cnt  = 0;
    logic [4:0] det_hist = '0;

    function automatic void push_word(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
`ifdef SER_LSB_FIRST_EN
            exp_q.push_back(d[i]);
`else
            exp_q.push_back(d[W-1-i]);
`endif
        end
    endfunction

    // Record transfers using the values present just before the edge.
    always @(posedge clk) begin
        if (rstn && s_valid && s_ready) push_word(s_data);
    end

    always @(negedge clk) begin : mon
        bit b;
        if (rstn) begin
            check("busy",      32'(busy),      32'(exp_q.size() != 0));
            check("s_ready",   32'(s_ready),   32'(exp_q.size() <= W));
            check("seq_valid", 32'(seq_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                check("seq_bit", 32'(seq), 32'(b));
                det_hist = {det_hist[3:0], seq};
                if (det_hist == 5'b11011) det_cnt++;
            end else begin
                check("seq_idle", 32'(seq), 32'(IDLE_BIT));
            end
        end
    end

    // Present a word until it is accepted, then drop valid and scramble data.
    task automatic send(input logic [W-1:0] d);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!s_ready) check("send_timeout", 32'(s_ready), 32'd1);
        else begin
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        s_data  = W'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_seq"},       32'(seq),       32'(IDLE_BIT));
        check({tag, "_seq_valid"}, 32'(seq_valid), 32'd0);
        check({tag, "_s_ready"},   32'(s_ready),   32'd1);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // ---------------- width sweep instances ----------------
    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int   LW  = (g == 0) ? 2 : 32;
        localparam logic LIB = (g == 0) ? 1'b1 : 1'b0;

        logic          l_rstn  = 1'b0;
        logic          l_valid = 1'b0;
        logic [LW-1:0] l_data  = '0;
        logic          l_ready, l_seq, l_seq_valid, l_busy;
        bit            l_q[$];
        bit            done = 1'b0;

        seq_serializer #(
            .WIDTH    (LW),
            .IDLE_BIT (LIB)
        ) u_dut (
            .clk       (clk),
            .rstn      (l_rstn),
            .s_data    (l_data),
            .s_valid   (l_valid),
            .s_ready   (l_ready),
            .seq       (l_seq),
            .seq_valid (l_seq_valid),
            .busy      (l_busy)
        );

        always @(posedge clk) begin
            if (l_rstn && l_valid && l_ready) begin
                for (int i = 0; i < LW; i++) begin
`ifdef SER_LSB_FIRST_EN
                    l_q.push_back(l_data[i]);
`else
                    l_q.push_back(l_data[LW-1-i]);
`endif
                end
            end
        end

        always @(negedge clk) begin : lmon
            bit b;
            if (l_rstn) begin
                check($sformatf("w%0d_busy", LW),      32'(l_busy),      32'(l_q.size() != 0));
                check($sformatf("w%0d_s_ready", LW),   32'(l_ready),     32'(l_q.size() <= LW));
                check($sformatf("w%0d_seq_valid", LW), 32'(l_seq_valid), 32'(l_q.size() != 0));
                if (l_q.size() != 0) begin
                    b = l_q.pop_front();
                    check($sformatf("w%0d_seq_bit", LW), 32'(l_seq), 32'(b));
                end else begin
                    check($sformatf("w%0d_seq_idle", LW), 32'(l_seq), 32'(LIB));
                end
            end
        end

        initial begin
            int n;
            repeat (2) @(negedge clk);
            #1 l_rstn = 1'b1;
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 4) == 0) begin
                    repeat ($urandom_range(1, 2 * LW)) @(posedge clk);
                    #1;
                end else begin
                    l_data  = LW'($urandom);
                    l_valid = 1'b1;
                    n = 0;
                    while (!l_ready && n < 200) begin
                        @(posedge clk); #1;
                        n++;
                    end
                    if (!l_ready) check($sformatf("w%0d_send_timeout", LW), 32'(l_ready), 32'd1);
                    else begin
                        @(posedge clk); #1;
                    end
                    l_valid = 1'b0;
                end
            end
            n = 0;
            while ((l_q.size() != 0 || l_busy) && n < 500) begin
                @(posedge clk); #1;
                n++;
            end
            check($sformatf("w%0d_drain", LW), 32'(l_q.size()), 32'd0);
            done = 1'b1;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int n;

        // Reset with no stimulus.
        #1;
        check_reset_outputs("in_reset");
        repeat (2) @(negedge clk);
        #1 rstn = 1'b1;
        check_reset_outputs("after_reset");
        idle(3);

        // Single word; detector sees 11011 twice (overlap).
        det_cnt  = 0;
        det_hist = '0;
        send(8'hDB);
        drain();
        check("detect_count_DB", 32'(det_cnt), 32'd2);

        // Back-to-back words with valid held: hold fills, s_ready drops.
        send(8'hDB);
        send(8'h1B);
        send(8'hA5);
        drain();

        // Gap of three cycles between words.
        send(8'h3C);
        drain();
        idle(3);
        send(8'hC3);
        drain();

        // Reset mid-word with the hold slot occupied.
        send(8'hFF);
        send(8'h5A);
        @(posedge clk); #3;
        rstn = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk); #1;
        rstn = 1'b1;
        send(8'h96);
        send(8'h1B);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 12));
            else send(W'($urandom));
        end
        drain();

        n = 0;
        while (!(g_lane[0].done && g_lane[1].done) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        check("sweep_done", 32'(g_lane[0].done && g_lane[1].done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_serializer
